fifo_sync_ctrl: RTL and testbench

Single-clock pointer and flag controller for the FIFO storage array. It owns the read and write pointers and qualifies write enables. It generates FULL/EMPTY, occupancy, programmable almost-full/almost-empty flags and sticky overflow/underflow errors. The storage array it drives has a combinational read port, so read data at R_PTR is valid whenever EMPTY=0.

---
 rtl/fifo_sync_ctrl_if.sv | 73 +++++++
 rtl/fifo_sync_ctrl.sv | 140 ++++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_ctrl_if.sv
// Interface for the FIFO pointer/flag controller.
//
// Handshake: a producer raises w_req and holds its data stable; the word is
// taken on a rising edge where w_en=1 (w_en = w_req & !full & !flush).
// A consumer raises r_req and samples storage data at r_ptr in that same
// cycle; the pop takes effect on a rising edge where r_req & !empty & !flush.
// A request that is not taken may simply be held or dropped; rejected
// requests against full/empty also set the sticky error flags.
interface fifo_sync_ctrl_if #(
  parameter int PTR_WIDTH = 5
);

  // Requests and configuration from the FIFO user side
  logic                 w_req;
  logic                 r_req;
  logic                 flush;
  logic                 clr_err;
  logic [PTR_WIDTH-1:0] af_thresh;
  logic [PTR_WIDTH-1:0] ae_thresh;

  // Storage control and status from the controller
  logic                 w_en;
  logic [PTR_WIDTH-1:0] w_ptr;
  logic [PTR_WIDTH-1:0] r_ptr;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [PTR_WIDTH-1:0] count;
  logic                 overflow;
  logic                 underflow;

  // User side: issues requests, observes status
  modport master (
    output w_req,
    output r_req,
    output flush,
    output clr_err,
    output af_thresh,
    output ae_thresh,
    input  w_en,
    input  w_ptr,
    input  r_ptr,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  // Controller side: consumes requests, drives status
  modport slave (
    input  w_req,
    input  r_req,
    input  flush,
    input  clr_err,
    input  af_thresh,
    input  ae_thresh,
    output w_en,
    output w_ptr,
    output r_ptr,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO pointer and flag controller.
// Owns read/write pointers (address bits plus one wrap bit), qualifies the
// storage write strobe, and derives full/empty/occupancy/almost flags purely
// from the registered pointers. Overflow/underflow are sticky until cleared.
module fifo_sync_ctrl #(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fifo_sync_ctrl_if.slave bus
);

  localparam logic [PTR_WIDTH-1:0] PTR_ZERO = '0;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  // The wrap-bit scheme only works when the address field exactly spans DEPTH
  generate
    if (DEPTH != (1 << (PTR_WIDTH - 1))) begin : g_bad_depth
      $error("fifo_sync_ctrl: DEPTH must equal 2**(PTR_WIDTH-1)");
    end
  endgenerate

  // Registered state: the two pointers fully define the FIFO contents
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic                 r_overflow;
  logic                 r_underflow;

  // Derived flags and qualified requests
  logic [PTR_WIDTH-1:0] w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_ovf_set;
  logic                 w_unf_set;
  logic [PTR_WIDTH-1:0] w_wr_ptr_nxt;
  logic [PTR_WIDTH-1:0] w_rd_ptr_nxt;
  logic                 w_overflow_nxt;
  logic                 w_underflow_nxt;

  // Status flags from registered pointers only, so they never glitch on requests
  always_comb begin
    w_count = r_wr_ptr - r_rd_ptr;
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[PTR_WIDTH-1] != r_rd_ptr[PTR_WIDTH-1]) &&
              (r_wr_ptr[PTR_WIDTH-2:0] == r_rd_ptr[PTR_WIDTH-2:0]);
  end

  // Request qualification: flush overrides everything, no pass-through or bypass
  always_comb begin
    w_push_ok = bus.w_req & ~w_full  & ~bus.flush;
    w_pop_ok  = bus.r_req & ~w_empty & ~bus.flush;
    w_ovf_set = bus.w_req &  w_full  & ~bus.flush;
    w_unf_set = bus.r_req &  w_empty & ~bus.flush;
  end

  // Next pointer values; natural binary wrap toggles the MSB at DEPTH-1 -> 0
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (bus.flush) begin
      w_wr_ptr_nxt = PTR_ZERO;
      w_rd_ptr_nxt = PTR_ZERO;
    end else begin
      if (w_push_ok) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky error next state: a new error in the same cycle beats the clear
  always_comb begin
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    if (bus.clr_err) begin
      w_overflow_nxt  = 1'b0;
      w_underflow_nxt = 1'b0;
    end
    if (w_ovf_set) begin
      w_overflow_nxt = 1'b1;
    end
    if (w_unf_set) begin
      w_underflow_nxt = 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Sticky error registers; flush deliberately leaves them alone
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // Output drive; almost flags are unsigned compares against live thresholds
  always_comb begin
    bus.w_en         = w_push_ok;
    bus.w_ptr        = r_wr_ptr;
    bus.r_ptr        = r_rd_ptr;
    bus.full         = w_full;
    bus.empty        = w_empty;
    bus.count        = w_count;
    bus.almost_full  = (w_count >= bus.af_thresh);
    bus.almost_empty = (w_count <= bus.ae_thresh);
    bus.overflow     = r_overflow;
    bus.underflow    = r_underflow;
  end

`ifndef SYNTHESIS
  // Structural sanity: the pointer pair can never encode both full and empty
  a_not_full_and_empty : assert property (
    @(posedge i_clk) disable iff (i_rst) !(w_full && w_empty)
  );

  // The write strobe must never fire into a full array
  a_no_write_when_full : assert property (
    @(posedge i_clk) disable iff (i_rst) !(w_push_ok && w_full)
  );
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed testbench for fifo_sync_ctrl with a small storage array model.
module tb_fifo_sync_ctrl;

  localparam int PW = 5;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] mem [0:15];
  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_fail;
  logic       wrapped_w;
  logic       wrapped_r;
  logic [PW-1:0] prev_w;
  logic [PW-1:0] prev_r;

  fifo_sync_ctrl_if #(.PTR_WIDTH(PW)) bus ();

  fifo_sync_ctrl #(.DEPTH(16), .PTR_WIDTH(PW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // Storage array: written on w_en, combinational read at r_ptr
  always @(posedge clk) begin
    if (bus.w_en) mem[bus.w_ptr[3:0]] <= wdata;
  end
  assign rdata = mem[bus.r_ptr[3:0]];

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic f, input logic c,
                       input logic [7:0] d);
    bus.w_req   = w;
    bus.r_req   = r;
    bus.flush   = f;
    bus.clr_err = c;
    wdata       = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wrapped_w = 1'b0;
    wrapped_r = 1'b0;
    rst = 1'b1;
    bus.af_thresh = 5'd0;
    bus.ae_thresh = 5'd3;
    drive(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_w_ptr", bus.w_ptr, 0);
    check("rst_r_ptr", bus.r_ptr, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_ae", bus.almost_empty, 1);
    check("rst_af_thr0", bus.almost_full, 1);
    check("rst_wen", bus.w_en, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_unf", bus.underflow, 0);
    bus.af_thresh = 5'd12;
    #1;
    check("rst_af_thr12", bus.almost_full, 0);
    rst = 1'b0;
    step();

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0, 8'(i));
      check("fill_wen", bus.w_en, 1);
      exp_q.push_back(8'(i));
      step();
      check("fill_count", bus.count, i + 1);
      if (i + 1 == 3)  check("fill_ae_at3", bus.almost_empty, 1);
      if (i + 1 == 4)  check("fill_ae_at4", bus.almost_empty, 0);
      if (i + 1 == 11) check("fill_af_at11", bus.almost_full, 0);
      if (i + 1 == 12) check("fill_af_at12", bus.almost_full, 1);
      if (i + 1 == 15) check("fill_full_at15", bus.full, 0);
    end
    check("fill_full", bus.full, 1);
    check("fill_w_ptr", bus.w_ptr, 5'h10);
    check("fill_r_ptr", bus.r_ptr, 5'h00);

    // 17th push rejected
    drive(1, 0, 0, 0, 8'hAA);
    check("push17_wen", bus.w_en, 0);
    step();
    check("push17_ovf", bus.overflow, 1);
    check("push17_w_ptr", bus.w_ptr, 5'h10);
    check("push17_count", bus.count, 16);

    // Drain 16 in order
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0, 8'h00);
      check("drain_data", rdata, exp_q.pop_front());
      step();
      check("drain_count", bus.count, 15 - i);
      if (15 - i == 12) check("drain_af_at12", bus.almost_full, 1);
      if (15 - i == 11) check("drain_af_at11", bus.almost_full, 0);
    end
    check("drain_empty", bus.empty, 1);
    check("drain_r_ptr", bus.r_ptr, 5'h10);

    // Extra pop, then clear errors
    drive(0, 1, 0, 0, 8'h00);
    step();
    check("pop_unf", bus.underflow, 1);
    check("pop_unf_r_ptr", bus.r_ptr, 5'h10);
    drive(0, 0, 0, 1, 8'h00);
    step();
    check("clr_ovf", bus.overflow, 0);
    check("clr_unf", bus.underflow, 0);

    // Wrap: hold COUNT=5 with push+pop for 40 cycles
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 8'(8'h20 + k));
      exp_q.push_back(8'(8'h20 + k));
      step();
    end
    check("wrap_pre_count", bus.count, 5);
    for (int k = 0; k < 40; k++) begin
      drive(1, 1, 0, 0, 8'(8'h25 + k));
      check("wrap_data", rdata, exp_q.pop_front());
      exp_q.push_back(8'(8'h25 + k));
      prev_w = bus.w_ptr;
      prev_r = bus.r_ptr;
      step();
      if (prev_w == 5'h1F && bus.w_ptr == 5'h00) wrapped_w = 1'b1;
      if (prev_r == 5'h1F && bus.r_ptr == 5'h00) wrapped_r = 1'b1;
      check("wrap_count", bus.count, 5);
      check("wrap_flags",
            {bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow},
            6'b000000);
    end
    check("wrap_seen_w", wrapped_w, 1);
    check("wrap_seen_r", wrapped_r, 1);
    check("wrap_w_ptr", bus.w_ptr, 5'h1D);
    check("wrap_r_ptr", bus.r_ptr, 5'h18);

    // Push+pop at FULL
    for (int k = 0; k < 11; k++) begin
      drive(1, 0, 0, 0, 8'(8'h50 + k));
      exp_q.push_back(8'(8'h50 + k));
      step();
    end
    check("bnd_full", bus.full, 1);
    drive(1, 1, 0, 0, 8'h77);
    check("bnd_full_wen", bus.w_en, 0);
    check("bnd_full_data", rdata, exp_q.pop_front());
    step();
    check("bnd_full_count", bus.count, 15);
    check("bnd_full_ovf", bus.overflow, 1);
    drive(1, 0, 0, 0, 8'h78);
    exp_q.push_back(8'h78);
    step();
    check("bnd_refill_full", bus.full, 1);
    drive(0, 0, 0, 1, 8'h00);
    step();
    check("bnd_clr_ovf", bus.overflow, 0);
    drive(1, 0, 0, 1, 8'h79);
    step();
    check("bnd_set_wins", bus.overflow, 1);

    // Pop to 10, live threshold change, pop to 9
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 0, 8'h00);
      check("thr_pop_data", rdata, exp_q.pop_front());
      step();
    end
    drive(0, 0, 0, 0, 8'h00);
    check("thr_count10", bus.count, 10);
    check("thr_af_12", bus.almost_full, 0);
    bus.af_thresh = 5'd8;
    #1;
    check("thr_af_8", bus.almost_full, 1);
    bus.af_thresh = 5'd12;
    drive(0, 1, 0, 0, 8'h00);
    check("thr_pop_data", rdata, exp_q.pop_front());
    step();
    check("thr_count9", bus.count, 9);

    // Flush with a push request
    drive(1, 0, 1, 0, 8'h99);
    check("flush_wen", bus.w_en, 0);
    step();
    check("flush_count", bus.count, 0);
    check("flush_empty", bus.empty, 1);
    check("flush_w_ptr", bus.w_ptr, 0);
    check("flush_r_ptr", bus.r_ptr, 0);
    check("flush_ovf_kept", bus.overflow, 1);
    check("flush_unf", bus.underflow, 0);
    exp_q.delete();

    // Push+pop at EMPTY
    drive(1, 1, 0, 0, 8'h55);
    check("bnd_empty_wen", bus.w_en, 1);
    exp_q.push_back(8'h55);
    step();
    check("bnd_empty_count", bus.count, 1);
    check("bnd_empty_unf", bus.underflow, 1);
    drive(0, 1, 0, 0, 8'h00);
    check("bnd_empty_data", rdata, exp_q.pop_front());
    step();
    check("bnd_empty_after", bus.empty, 1);

    // Asynchronous reset mid-burst
    drive(1, 0, 0, 0, 8'h61);
    step();
    drive(1, 0, 0, 0, 8'h62);
    step();
    check("mid_w_ptr_pre", bus.w_ptr, 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_w_ptr", bus.w_ptr, 0);
    check("arst_r_ptr", bus.r_ptr, 0);
    check("arst_count", bus.count, 0);
    check("arst_empty", bus.empty, 1);
    check("arst_ovf", bus.overflow, 0);
    check("arst_unf", bus.underflow, 0);
    drive(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
